// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtraction controller: FSM state encoding
// and a reference model of the single-bit full subtracter cell.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {borrow, diff} of A - B - Bin for one bit position.
    function automatic logic [1:0] fs_ref(input logic i_a, input logic i_b, input logic i_bin);
        logic w_d;
        logic w_bo;
        w_d  = i_a ^ i_b ^ i_bin;
        w_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
        return {w_bo, w_d};
    endfunction

endpackage

// File: rtl/Full_Subtracter.sv
// Single-bit full subtracter cell: Diff = A - B - Bin, with borrow-out.
module Full_Subtracter (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Borrow
);

    assign Diff   = A ^ B ^ Bin;
    assign Borrow = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin: one shared full subtracter cell is stepped over
// WIDTH cycles, LSB first, under a start/done handshake.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;

    logic             w_cell_diff;
    logic             w_cell_borrow;
    logic [WIDTH-1:0] w_res_next;

    Full_Subtracter u_cell (
        .A      (r_a_sh[0]),
        .B      (r_b_sh[0]),
        .Bin    (r_brw),
        .Diff   (w_cell_diff),
        .Borrow (w_cell_borrow)
    );

    // Result fills from the MSB so the first (LSB) bit ends up at bit 0.
    assign w_res_next = {w_cell_diff, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_brw    <= w_cell_borrow;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Final bit: publish the full result on the same edge.
                    if (r_cnt == LAST_CNT) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_cell_borrow;
                        r_zero   <= (w_res_next == '0);
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign busy   = (r_state == SHIFT) || (r_state == DONE);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtraction controller that computes A - B - Bin by sequencing one shared single-bit full subtracter cell over WIDTH cycles, LSB first. Handshake is start/done. The controller holds the operand shift registers, the borrow flop and the result register. It sits between a requesting datapath or control unit and the full subtracter cell, and trades latency for area against a WIDTH-bit parallel ripple subtractor.

Parameters:
WIDTH, 8, operand/result bit width; legal values 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, must not be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  initial borrow-in; captured on accepted start
ready  output  1  high in IDLE only
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  registered difference
borrow  output  1  registered final borrow-out (1 = A < B + Bin)
zero  output  1  registered, diff == 0

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, diff=0, borrow=0, zero=0, done=0, busy=0, ready=1. Internal shift registers, counter and borrow flop are cleared. An in-flight operation is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. The clock edge with start=1 latches a, b and bin into a_sh, b_sh and brw_r, sets cnt=0 and moves to SHIFT. diff, borrow and zero keep their previous values until DONE.
- SHIFT: the cell inputs are A=a_sh[0], B=b_sh[0], Bin=brw_r.
- SHIFT, each edge: a_sh and b_sh shift right by 1; the cell Diff shifts into the MSB of res_sh (shift right); brw_r takes the cell Borrow; cnt increments.
- SHIFT exit: when cnt == WIDTH-1 at the edge, the final bit is processed and the state moves to DONE. The FSM is in SHIFT for exactly WIDTH cycles.
- DONE, entry edge: diff=res_sh (including the final bit), borrow=brw_r (final), zero=(diff==0).
- DONE: done=1 for exactly one cycle, ready=0, then unconditional move to IDLE.
- Latency: for a start accepted at edge N, done is high during the cycle after edge N+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy: ignored. Operands are not recaptured and the current operation is not disturbed.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Cell equations: Diff = A^B^Bin; Borrow = (~A&B) | (~(A^B)&Bin).
- Arithmetic: {borrow, diff} equals the (WIDTH+1)-bit two's-complement result of a - b - bin, i.e. diff = (a - b - bin) mod 2^WIDTH.
- No X propagation: all outputs are driven from flops or from the FSM decode of state.

Decomposition:
- Shared package serial_sub_pkg holds the state enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the cell equations as a reference function for scoreboards.
- The one natural sub-module is the existing single-bit Full_Subtracter cell (ports A, B, Bin, Diff, Borrow), instantiated once, purely combinational.
- All sequencing lives in serial_sub_ctrl.

Test Plan:
1. WIDTH=8; a=8'h5A, b=8'h3C, bin=0, start pulse -> done exactly 9 cycles after the accepting edge; diff=8'h1E, borrow=0, zero=0.
2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow=1, zero=0; then a=8'h01, b=8'h00, bin=1 -> diff=8'h00, borrow=0, zero=1.
3. a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, borrow=0, zero=1. This exercises the bin path through all bits.
4. Start accepted with a=8'h10, b=8'h01; pulse start with a=8'hFF, b=8'h00 during SHIFT cycle 3 -> result is still 8'h0F with one done pulse only; ready stays 0 until after DONE.
5. rst_n driven low asynchronously mid-SHIFT (cycle 4) -> ready=1, busy=0, done=0, diff=0, borrow=0 immediately, with no later done pulse. A fresh 8'h05-8'h03 then gives 8'h02.
6. start held high for 30 cycles with a, b randomised per accept -> back-to-back operations with a period of 10 cycles. Each {borrow, diff} matches the scoreboard value of a - b - bin.
